uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets four requesters share one uart_tx.
// Each grant sends an optional header byte and then the requester's data byte.
module uart_tx_arbiter #(
  parameter bit          HEADER_EN = 1'b1,
  parameter int unsigned TIMEOUT   = 1023
) (
  input  logic        RST_clk,
  input  logic        RST_n,
  input  logic [3:0]  req,
  input  logic [31:0] req_data,
  output logic [3:0]  ack,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        uart_busy,
  output logic [1:0]  grant_id,
  output logic        active,
  output logic        timeout_err
);

  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {IDLE, GRANT, SEND, WAIT_HI, WAIT_LO, DONE} state_t;
  typedef enum logic {HEADER, DATA} byte_sel_t;

  state_t      state;
  byte_sel_t   byte_sel;
  logic [1:0]  rr_ptr;
  logic [7:0]  data_byte;
  logic [CW-1:0] cnt;

  logic [1:0]  pick;
  logic        found;
  logic [1:0]  idx;
  logic [7:0]  cur_byte;
  logic [7:0]  header_byte;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = rr_ptr + 2'(i);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  assign cur_byte    = req_data[{grant_id, 3'b000} +: 8];
  assign header_byte = {4'hA, 2'b00, grant_id};

  // grant_id is captured on leaving IDLE so the data byte can be picked in GRANT
  always_ff @(posedge RST_clk) begin
    if (RST_n) begin
      state       <= IDLE;
      byte_sel    <= HEADER;
      rr_ptr      <= '0;
      data_byte   <= '0;
      cnt         <= '0;
      tx_data     <= 8'h00;
      tx_start    <= 1'b0;
      ack         <= '0;
      grant_id    <= '0;
      active      <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      ack      <= '0;
      case (state)
        IDLE: begin
          if (|req) begin
            grant_id <= pick;
            active   <= 1'b1;
            state    <= GRANT;
          end
        end
        GRANT: begin
          data_byte <= cur_byte;
          if (HEADER_EN) begin
            byte_sel <= HEADER;
            tx_data  <= header_byte;
          end else begin
            byte_sel <= DATA;
            tx_data  <= cur_byte;
          end
          tx_start <= 1'b1;
          state    <= SEND;
        end
        SEND: begin
          cnt   <= '0;
          state <= WAIT_HI;
        end
        WAIT_HI: begin
          if (uart_busy) begin
            state <= WAIT_LO;
          end else if (cnt == CW'(TIMEOUT)) begin
            // busy never rose: flag it and let WAIT_LO retire the byte
            timeout_err <= 1'b1;
            state       <= WAIT_LO;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_LO: begin
          if (!uart_busy) begin
            if (byte_sel == HEADER) begin
              byte_sel <= DATA;
              tx_data  <= data_byte;
              tx_start <= 1'b1;
              state    <= SEND;
            end else begin
              ack   <= 4'b0001 << grant_id;
              state <= DONE;
            end
          end
        end
        DONE: begin
          rr_ptr   <= grant_id + 2'd1;
          byte_sel <= HEADER;
          active   <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state  <= IDLE;
          active <= 1'b0;
        end
      endcase
    end
  end

endmodule
